// File: rtl/dmem_if.sv
// Processor-side data memory port: request fields travel master->slave, completion fields slave->master.
// Handshake: req is sampled only while the responder is idle (busy=0); one sample of req=1 is one access.
// The access completes with a single-cycle ready pulse. err and rdata are meaningful only while ready=1.
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rdata, err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory that answers each accepted access after WAIT_CYCLES wait states.
// Storage lives in flops so that reset can clear every word.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  dmem_if.slave      bus,
  output logic [1:0] o_dbg_state
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic        r_ready;
  logic        r_err;
  logic [31:0] r_rdata;

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_a_we;
  logic [31:0]   w_a_addr;
  logic [31:0]   w_a_wdata;
  logic [3:0]    w_a_be;
  logic [AW-1:0] w_a_idx;
  logic          w_a_ok;
  logic [31:0]   w_old;
  logic [31:0]   w_new;

  assign w_accept     = (r_state == S_IDLE) && bus.req;
  assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd0));

  // With zero wait states the access happens on the accept edge, before the latches hold the request.
  assign w_a_we    = (r_state == S_IDLE) ? bus.we    : r_we;
  assign w_a_addr  = (r_state == S_IDLE) ? bus.addr  : r_addr;
  assign w_a_wdata = (r_state == S_IDLE) ? bus.wdata : r_wdata;
  assign w_a_be    = (r_state == S_IDLE) ? bus.be    : r_be;

  assign w_a_idx = w_a_addr[AW+1:2];
  assign w_a_ok  = (w_a_addr[1:0] == 2'b00) && (w_a_addr[31:AW+2] == '0);
  assign w_old   = r_mem[w_a_idx];

  always_comb begin
    w_new = w_old;
    for (int i = 0; i < 4; i++) begin
      if (w_a_be[i]) w_new[8*i +: 8] = w_a_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_we    <= bus.we;
            r_addr  <= bus.addr;
            r_wdata <= bus.wdata;
            r_be    <= bus.be;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // Rejected accesses leave storage alone and return zero data.
      if (w_enter_resp) begin
        r_ready <= 1'b1;
        if (!w_a_ok) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end else if (w_a_we) begin
          r_mem[w_a_idx] <= w_new;
          r_rdata        <= w_new;
        end else begin
          r_rdata <= w_old;
        end
      end
    end
  end

  assign bus.ready   = r_ready;
  assign bus.rdata   = r_rdata;
  assign bus.err     = r_err;
  assign bus.busy    = (r_state != S_IDLE);
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a 2-wait-state instance driven from a vector table plus multi-cycle sequences,
// and a zero-wait instance for latency and back-to-back throughput.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_if bus0();
  dmem_if bus1();
  logic [1:0] dbg0, dbg1;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .o_dbg_state(dbg0)
  );
  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .o_dbg_state(dbg1)
  );

  int total = 0;
  int bad = 0;
  int err_viol = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[17];

  // err must never be high without ready, on either instance
  always @(negedge clk) begin
    if ((bus0.err && !bus0.ready) || (bus1.err && !bus1.ready)) err_viol++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic rq, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (w == 0) begin
      bus0.req = rq; bus0.we = we; bus0.addr = a; bus0.wdata = d; bus0.be = be;
    end else begin
      bus1.req = rq; bus1.we = we; bus1.addr = a; bus1.wdata = d; bus1.be = be;
    end
  endtask

  function automatic logic get_ready(input int w);
    return (w == 0) ? bus0.ready : bus1.ready;
  endfunction
  function automatic logic get_err(input int w);
    return (w == 0) ? bus0.err : bus1.err;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 0) ? bus0.busy : bus1.busy;
  endfunction
  function automatic logic [31:0] get_rdata(input int w);
    return (w == 0) ? bus0.rdata : bus1.rdata;
  endfunction

  // Called at a negedge with the target idle; returns at a negedge with the target idle again.
  task automatic access(input int w, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
    drive(w, 1'b1, we, a, d, be);
    @(negedge clk);
    drive(w, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
    lat = 0;
    while (!get_ready(w) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = get_rdata(w);
    er = get_err(w);
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [11:0] rdy_v, busy_v;
  logic [31:0] held_rd;
  int          pulses;

  initial begin
    vecs[0]  = '{1'b1, 32'h44,  32'h0000_0007, 4'hF, 32'h0000_0007, 1'b0};
    vecs[1]  = '{1'b0, 32'h44,  32'h0,         4'h0, 32'h0000_0007, 1'b0};
    vecs[2]  = '{1'b1, 32'h10,  32'hAABB_CCDD, 4'hF, 32'hAABB_CCDD, 1'b0};
    vecs[3]  = '{1'b1, 32'h10,  32'h1122_3344, 4'h5, 32'hAA22_CC44, 1'b0};
    vecs[4]  = '{1'b0, 32'h10,  32'h0,         4'hF, 32'hAA22_CC44, 1'b0};
    vecs[5]  = '{1'b1, 32'h40,  32'h1234_5678, 4'hF, 32'h1234_5678, 1'b0};
    vecs[6]  = '{1'b0, 32'h42,  32'h0,         4'hF, 32'h0,         1'b1};
    vecs[7]  = '{1'b0, 32'h100, 32'h0,         4'hF, 32'h0,         1'b1};
    vecs[8]  = '{1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b1};
    vecs[9]  = '{1'b1, 32'h42,  32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[10] = '{1'b0, 32'h40,  32'h0,         4'h0, 32'h1234_5678, 1'b0};
    vecs[11] = '{1'b1, 32'h40,  32'hFFFF_FFFF, 4'h0, 32'h1234_5678, 1'b0};
    vecs[12] = '{1'b1, 32'h40,  32'h9A00_0000, 4'h8, 32'h9A34_5678, 1'b0};
    vecs[13] = '{1'b0, 32'hFC,  32'h0,         4'hF, 32'h0,         1'b0};
    vecs[14] = '{1'b1, 32'hFC,  32'hCAFE_F00D, 4'h3, 32'h0000_F00D, 1'b0};
    vecs[15] = '{1'b0, 32'hFC,  32'h0,         4'h0, 32'h0000_F00D, 1'b0};
    vecs[16] = '{1'b0, 32'h44,  32'h0,         4'hF, 32'h0000_0007, 1'b0};

    // reset with a request pending on both instances: it must be ignored
    reset = 1'b1;
    drive(0, 1'b1, 1'b1, 32'h44, 32'hFFFF_FFFF, 4'hF);
    drive(1, 1'b1, 1'b1, 32'h44, 32'hFFFF_FFFF, 4'hF);
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, bus0.ready}, 32'd0);
    check("rst_err",   {31'd0, bus0.err},   32'd0);
    check("rst_busy",  {31'd0, bus0.busy},  32'd0);
    check("rst_rdata", bus0.rdata,          32'd0);
    check("rst_state", {30'd0, dbg0},       32'd0);
    check("rst_busy1", {31'd0, bus1.busy},  32'd0);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("post_rst_idle", {31'd0, bus0.busy}, 32'd0);

    // table-driven accesses on the 2-wait instance
    for (int i = 0; i < 17; i++) begin
      access(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d_lat", i), 32'(lat), 32'd2);
      check($sformatf("v%0d_idle", i), {31'd0, get_busy(0)}, 32'd0);
    end

    // req held high for 12 edges: accepts only in IDLE, pulses 4 cycles apart
    drive(0, 1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
    held_rd = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rdy_v[i]  = bus0.ready;
      busy_v[i] = bus0.busy;
      if (bus0.ready) held_rd = bus0.rdata;
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("held_ready_pattern", {20'd0, rdy_v},  {20'd0, 12'h444});
    check("held_busy_pattern",  {20'd0, busy_v}, {20'd0, 12'h777});
    check("held_rdata", held_rd, 32'h0000_0007);
    @(negedge clk);
    check("held_end_idle", {31'd0, bus0.busy}, 32'd0);

    // zero-wait instance: same-cycle completion and 2-cycle throughput
    access(1, 1'b1, 32'h44, 32'h7, 4'hF, rd, er, lat);
    check("zw_wr_lat", 32'(lat), 32'd0);
    check("zw_wr_rdata", rd, 32'h7);
    access(1, 1'b0, 32'h44, 32'h0, 4'h0, rd, er, lat);
    check("zw_rd_lat", 32'(lat), 32'd0);
    check("zw_rd_rdata", rd, 32'h7);
    check("zw_rd_err", {31'd0, er}, 32'd0);
    access(1, 1'b0, 32'h42, 32'h0, 4'hF, rd, er, lat);
    check("zw_bad_err", {31'd0, er}, 32'd1);
    check("zw_bad_rdata", rd, 32'd0);
    drive(1, 1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rdy_v[i]  = bus1.ready;
      busy_v[i] = bus1.busy;
    end
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("zw_b2b_ready", {26'd0, rdy_v[5:0]},  32'h15);
    check("zw_b2b_busy",  {26'd0, busy_v[5:0]}, 32'h15);
    @(negedge clk);

    // reset during WAIT aborts the write and clears storage
    drive(0, 1'b1, 1'b1, 32'h8, 32'h5, 4'hF);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("abort_in_wait", {30'd0, dbg0}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, bus0.busy}, 32'd0);
    check("abort_state", {30'd0, dbg0}, 32'd0);
    reset = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus0.ready) pulses++;
    end
    check("abort_no_ready", 32'(pulses), 32'd0);
    access(0, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat);
    check("abort_rd8", rd, 32'd0);
    check("abort_rd8_err", {31'd0, er}, 32'd0);
    access(0, 1'b0, 32'h44, 32'h0, 4'hF, rd, er, lat);
    check("cleared_rd44", rd, 32'd0);
    access(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    check("cleared_rd10", rd, 32'd0);

    check("err_only_with_ready", 32'(err_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, meaning the number of 32-bit storage words (power of two, 4..256).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted before each response (0..15).
REQ-003 SHALL have one clock and one reset: clock named clk, reset named reset; reset synchronous, active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req  input  1  access request from the processor-side initiator.
REQ-007 we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  32  byte address; sampled with req.
REQ-009 wdata  input  32  write data; sampled with req.
REQ-010 be  input  4  byte enables; be[i] selects wdata[8i+7:8i]; sampled with req.
REQ-011 ready  output  1  one-cycle pulse marking completion of the accepted access.
REQ-012 rdata  output  32  read data; valid while ready=1.
REQ-013 err  output  1  qualifies ready; 1 = access rejected.
REQ-014 busy  output  1  1 whenever the FSM is not IDLE.

Function
REQ-015 FSM SHALL have states IDLE, WAIT and RESP; all outputs registered or decoded from state only, never combinational from inputs.
REQ-016 req SHALL be sampled only in IDLE; req=1 at edge E0 accepts the access and latches we/addr/wdata/be.
REQ-017 On accept: WAIT_CYCLES>0 -> WAIT with counter loaded to WAIT_CYCLES-1; WAIT_CYCLES=0 -> RESP directly.
REQ-018 WAIT SHALL decrement the counter each edge and go to RESP at the edge where the counter is 0.
REQ-019 The edge entering RESP SHALL perform the access; ready=1 for exactly the cycle after edge E0+WAIT_CYCLES.
REQ-020 RESP SHALL always return to IDLE at the next edge; earliest next accept is edge E0+WAIT_CYCLES+2.
REQ-021 req held high through WAIT/RESP SHALL NOT create an extra access; only sampling in IDLE counts.
REQ-022 Input changes after accept SHALL have no effect on the in-flight access.
REQ-023 Word index = addr[31:2]; addr[1:0]!=0 or index>=DEPTH_WORDS SHALL reject the access: err=1 with ready, no write, rdata=0.
REQ-024 Write: only bytes with be[i]=1 updated; be=0000 SHALL complete normally with no storage change.
REQ-025 Read: rdata SHALL equal the full word at the index (be ignored), captured on the edge entering RESP.
REQ-026 rdata SHALL hold its last value until the next RESP entry; err SHALL be 0 whenever ready=0.
REQ-027 Write responses SHALL drive rdata with the written word's post-write value.
REQ-028 busy SHALL be 1 in WAIT and RESP, 0 in IDLE.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE, counter=0, ready=0, err=0, busy=0, rdata=0, and clear all storage words to 0.
REQ-030 reset SHALL take priority over any simultaneous req or in-flight access; an aborted write SHALL NOT modify storage.
REQ-031 req sampled while reset=1 SHALL be ignored; first accept possible at the first edge with reset=0.

Verification (DEPTH_WORDS=64, WAIT_CYCLES=2 unless stated)
REQ-032 Write 0x00000007 to addr 0x44, be=1111, then read 0x44 -> ready 1 cycle after edge E0+2 each, err=0, read rdata=0x00000007.
REQ-033 Write 0xAABBCCDD to 0x10 with be=1111, then write 0x11223344 with be=0101, read 0x10 -> rdata=0xAA22CC44.
REQ-034 Read addr 0x42 and addr 0x100 -> ready with err=1, rdata=0; subsequent read of 0x40 shows no storage change.
REQ-035 req held high continuously for 12 cycles -> exactly 3 accesses, ready pulses spaced 4 cycles apart, busy low 1 cycle between.
REQ-036 Write 0x5 to 0x8, assert reset during WAIT -> ready never pulses, busy=0 after the reset edge, read 0x8 returns 0.
REQ-037 WAIT_CYCLES=0: read 0x44 after write 0x7 -> ready in cycle after accept edge, rdata=0x7, back-to-back accepts every 2 cycles.
